vga_fb_arbiter: RTL

//  Shares one single-port framebuffer RAM between the VGA scanout path and the CPU bus.
//  A scanout burst is one line prefetch of BURST_LEN consecutive reads started by scan_req.

---
 rtl/vga_fb_arbiter_if.sv | 24 ++
 rtl/vga_fb_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter_if.sv
// CPU-side bus of the framebuffer arbiter: a held request with a one-cycle
// grant pulse, plus the read-data return path.
interface vga_fb_arbiter_if #(
   parameter int ADDR_BITS = 16,
   parameter int DATA_BITS = 32
);
   logic                 cpu_valid;
   logic                 cpu_we;
   logic [ADDR_BITS-1:0] cpu_addr;
   logic [DATA_BITS-1:0] cpu_wdata;
   logic                 cpu_ready;
   logic                 cpu_rvalid;
   logic [DATA_BITS-1:0] cpu_rdata;

   modport master (
      output cpu_valid, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_ready, cpu_rvalid, cpu_rdata
   );

   modport slave (
      input  cpu_valid, cpu_we, cpu_addr, cpu_wdata,
      output cpu_ready, cpu_rvalid, cpu_rdata
   );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scanout line bursts have absolute priority,
// CPU reads/writes are slotted in between bursts.
module vga_fb_arbiter #(
   parameter int ADDR_BITS = 16,
   parameter int DATA_BITS = 32,
   parameter int BURST_LEN = 160,
   parameter int WAIT_BITS = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 scan_req,
   input  logic [ADDR_BITS-1:0] scan_addr,
   output logic                 scan_rvalid,
   output logic [DATA_BITS-1:0] scan_rdata,
   output logic                 scan_busy,
   output logic                 scan_ovr,
   vga_fb_arbiter_if.slave      cpu,
   output logic [WAIT_BITS-1:0] cpu_wait,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [DATA_BITS-1:0] mem_wdata,
   input  logic [DATA_BITS-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, SCAN, CPU} state_t;

   localparam int CNT_BITS = $clog2(BURST_LEN + 1);
   localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(BURST_LEN - 1);
   localparam logic [WAIT_BITS-1:0] WSAT = '1;

   state_t state, state_nxt;

   logic [CNT_BITS-1:0]  cnt, cnt_nxt;
   logic                 pend, pend_nxt;
   logic [ADDR_BITS-1:0] pend_addr, pend_addr_nxt;
   logic                 ovr_nxt, busy_nxt;
   logic                 en_nxt, we_nxt;
   logic [ADDR_BITS-1:0] addr_nxt, start_addr;
   logic [DATA_BITS-1:0] wdata_nxt;
   logic                 start, grant;
   logic                 ready_q, crv_q;
   logic [WAIT_BITS-1:0] wcnt, wcnt_nxt, wait_nxt;

   assign cpu.cpu_ready  = ready_q;
   assign cpu.cpu_rvalid = crv_q;
   assign cpu.cpu_rdata  = mem_rdata;
   assign scan_rdata     = mem_rdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= '0;
         pend        <= 1'b0;
         pend_addr   <= '0;
         scan_ovr    <= 1'b0;
         scan_busy   <= 1'b0;
         scan_rvalid <= 1'b0;
         crv_q       <= 1'b0;
         ready_q     <= 1'b0;
         mem_en      <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         wcnt        <= '0;
         cpu_wait    <= '0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         pend        <= pend_nxt;
         pend_addr   <= pend_addr_nxt;
         scan_ovr    <= ovr_nxt;
         scan_busy   <= busy_nxt;
         // the state register tells which requester owns the read in flight
         scan_rvalid <= mem_en && !mem_we && (state == SCAN);
         crv_q       <= mem_en && !mem_we && (state == CPU);
         ready_q     <= grant;
         mem_en      <= en_nxt;
         mem_we      <= we_nxt;
         mem_addr    <= addr_nxt;
         mem_wdata   <= wdata_nxt;
         wcnt        <= wcnt_nxt;
         cpu_wait    <= wait_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      pend_nxt      = pend;
      pend_addr_nxt = pend_addr;
      ovr_nxt       = scan_ovr;
      en_nxt        = 1'b0;
      we_nxt        = 1'b0;
      addr_nxt      = mem_addr;
      wdata_nxt     = mem_wdata;
      start         = 1'b0;
      start_addr    = scan_addr;
      grant         = 1'b0;

      unique case (state)
         IDLE: begin
            if (pend) begin
               start      = 1'b1;
               start_addr = pend_addr;
               pend_nxt   = 1'b0;
               ovr_nxt    = scan_ovr | scan_req;
            end else if (scan_req) begin
               start = 1'b1;
            end else if (cpu.cpu_valid) begin
               grant = 1'b1;
            end
         end
         SCAN: begin
            if (cnt == LAST) begin
               if (scan_req) start = 1'b1;
               else state_nxt = IDLE;
            end else begin
               ovr_nxt  = scan_ovr | scan_req;
               en_nxt   = 1'b1;
               addr_nxt = mem_addr + 1'b1;
               cnt_nxt  = cnt + 1'b1;
            end
         end
         CPU: begin
            // no arbitration here, so a held cpu_valid is never granted twice
            state_nxt = IDLE;
            if (scan_req) begin
               pend_nxt      = 1'b1;
               pend_addr_nxt = scan_addr;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (start) begin
         state_nxt = SCAN;
         cnt_nxt   = '0;
         en_nxt    = 1'b1;
         addr_nxt  = start_addr;
      end

      if (grant) begin
         state_nxt = CPU;
         en_nxt    = 1'b1;
         we_nxt    = cpu.cpu_we;
         addr_nxt  = cpu.cpu_addr;
         wdata_nxt = cpu.cpu_wdata;
      end

      busy_nxt = (state_nxt == SCAN) || pend_nxt;
   end

   always_comb begin
      wcnt_nxt = wcnt;
      wait_nxt = cpu_wait;
      if (grant) begin
         wait_nxt = (wcnt > cpu_wait) ? wcnt : cpu_wait;
         wcnt_nxt = '0;
      end else if (cpu.cpu_valid && (state != CPU) && (wcnt != WSAT)) begin
         wcnt_nxt = wcnt + 1'b1;
      end
   end

endmodule
